// File: rtl/serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// serial_tx_arbiter
//
// Shares one AVR serial transmitter between NUM_REQ message sources.
// Arbitration is round-robin at message granularity. A burst cap limits
// how many bytes one grant may send, so no source can hold the link for
// an unbounded time.
//
// Handshake: req[i] acts as "valid" for the byte on req_data[8i+7:8i]
// (with req_last[i]). req_ack[i] is the consume strobe. It is asserted
// combinationally only in SEND, only for the granted requester, and only
// while req[i] is high. A requester must present its next byte, or drop
// req, by the cycle after req_ack.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ready         AVR ready; low forces IDLE and drops the grant
//   req           per-requester byte available
//   req_data      packed bytes, requester i at [8i+7:8i]
//   req_last      byte is the last of its message
//   req_ack       byte of granted requester consumed this cycle
//   grant         one-hot link owner, zero when idle
//   tx_data       byte to the transmitter (holds between strobes)
//   new_tx_data   one-cycle strobe qualifying tx_data
//   tx_busy       transmitter busy
//   state_dbg     current FSM state (0 IDLE, 1 SEND, 2 HOLD, 3 WAIT)
// ---------------------------------------------------------------------------
module serial_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ready,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   new_tx_data,
  input  logic                   tx_busy,
  output logic [1:0]             state_dbg
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   g_idx, g_idx_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               last_flag, last_nxt;
  logic [7:0]         tx_data_nxt;
  logic               new_tx_nxt;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               req_sel;
  logic [7:0]         data_sel;
  logic               last_sel;

  // Round-robin search starting just after the last released owner.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Signals of the currently granted requester.
  assign req_sel  = req[g_idx];
  assign data_sel = req_data[{g_idx, 3'b000} +: 8];
  assign last_sel = req_last[g_idx];

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    g_idx_nxt   = g_idx;
    ptr_nxt     = ptr;
    count_nxt   = count;
    last_nxt    = last_flag;
    tx_data_nxt = tx_data;
    new_tx_nxt  = 1'b0;
    req_ack     = '0;

    if (!ready) begin
      // Link unusable: abandon the grant. ptr is kept so the requester that
      // was cut off is not penalised when the link comes back.
      state_nxt = ST_IDLE;
      grant_nxt = '0;
      count_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            g_idx_nxt = win_idx;
            count_nxt = '0;
            state_nxt = ST_SEND;
          end
        end
        ST_SEND: begin
          if (req_sel) begin
            req_ack     = grant;
            tx_data_nxt = data_sel;
            new_tx_nxt  = 1'b1;
            last_nxt    = last_sel;
            count_nxt   = count + CNT_W'(1);
            state_nxt   = ST_HOLD;
          end else begin
            // Source withdrew its message: release without a strobe.
            grant_nxt = '0;
            ptr_nxt   = g_idx;
            state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: begin
          // tx_busy lags the strobe by a cycle, so it is not looked at here.
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (!tx_busy) begin
            if (last_flag || (count == CNT_W'(MAX_BURST))) begin
              grant_nxt = '0;
              ptr_nxt   = g_idx;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_SEND;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      g_idx       <= '0;
      ptr         <= IDX_W'(NUM_REQ - 1);
      count       <= '0;
      last_flag   <= 1'b0;
      tx_data     <= 8'h00;
      new_tx_data <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      g_idx       <= g_idx_nxt;
      ptr         <= ptr_nxt;
      count       <= count_nxt;
      last_flag   <= last_nxt;
      tx_data     <= tx_data_nxt;
      new_tx_data <= new_tx_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
module tb_serial_tx_arbiter;

  localparam int NR = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          ready;
  logic [NR-1:0] req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ack;
  logic [NR-1:0] grant;
  logic [7:0]    tx_data;
  logic          new_tx_data;
  logic          tx_busy;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  serial_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .req(req), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .grant(grant), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .tx_busy(tx_busy), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- transmitter model ----------------
  int busy_len = 10;
  int busy_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (new_tx_data) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // ---------------- requester sources ----------------
  logic [8:0] src_mem [NR][16];
  int         src_rd [NR];
  int         src_wr [NR];
  logic [NR-1:0] ack_q = '0;

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      req[i] = (src_rd[i] < src_wr[i]);
      if (src_rd[i] < src_wr[i]) {req_last[i], req_data[8*i +: 8]} = src_mem[i][src_rd[i]];
      else begin
        req_last[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    refresh();
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    src_mem[r][src_wr[r]] = {l, d};
    src_wr[r]++;
    refresh();
  endtask

  always @(posedge clk) ack_q <= req_ack;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++)
      if (ack_q[i] && src_rd[i] < src_wr[i]) src_rd[i]++;
    refresh();
  end

  // ---------------- strobe monitor / scoreboard ----------------
  logic [7:0]  log_data [64];
  logic [3:0]  log_grant [64];
  int          log_cyc [64];
  int          n_log = 0;
  logic [11:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && new_tx_data && n_log < 64) begin
      log_data[n_log]  = tx_data;
      log_grant[n_log] = grant;
      log_cyc[n_log]   = cyc;
      n_log++;
    end
    if (rst_n && req_ack != '0) check("ack_eq_grant", req_ack, grant);
  end

  task automatic compare_log(input string tag);
    check({tag, "_count"}, n_log, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_log; i++)
      check(tag, {log_grant[i], log_data[i]}, exp_q[i]);
    exp_q.delete();
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int n, input int limit);
    int k = 0;
    while (n_log < n && k < limit) begin
      tick();
      k++;
    end
    check("strobes_reached", n_log, n);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (state_dbg != 2'd0 && k < limit) begin
      tick();
      k++;
    end
    check("idle_reached", state_dbg, 2'd0);
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    clear_sources();
    n_log = 0;
    tick();
  endtask

  task automatic end_reset();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  int t0;
  int k;

  initial begin
    rst_n = 1'b0;
    ready = 1'b1;
    clear_sources();
    tick();
    tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_ack", req_ack, 4'b0000);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_new_tx", new_tx_data, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    end_reset();

    // Single source, 10-cycle busy: strobes at relative cycles 2, 15, 28.
    busy_len = 10;
    t0 = cyc;
    load(0, 8'hA1, 1'b0);
    load(0, 8'hA2, 1'b0);
    load(0, 8'hA3, 1'b1);
    wait_strobes(3, 100);
    wait_idle(40);
    exp_q.push_back({4'b0001, 8'hA1});
    exp_q.push_back({4'b0001, 8'hA2});
    exp_q.push_back({4'b0001, 8'hA3});
    compare_log("single");
    check("single_cyc0", log_cyc[0] - t0, 2);
    check("single_cyc1", log_cyc[1] - t0, 15);
    check("single_cyc2", log_cyc[2] - t0, 28);
    check("single_grant_end", grant, 4'b0000);

    // Round-robin: 0, 1, 3 requesting from reset, then 0 again.
    busy_len = 2;
    start_reset();
    load(0, 8'h10, 1'b1);
    load(1, 8'h11, 1'b1);
    load(3, 8'h13, 1'b1);
    end_reset();
    wait_strobes(3, 100);
    wait_idle(20);
    load(0, 8'h20, 1'b1);
    wait_strobes(4, 40);
    wait_idle(20);
    exp_q.push_back({4'b0001, 8'h10});
    exp_q.push_back({4'b0010, 8'h11});
    exp_q.push_back({4'b1000, 8'h13});
    exp_q.push_back({4'b0001, 8'h20});
    compare_log("rr");

    // Burst cap of 4: requester 2 streams 10 bytes, requester 1 contends.
    start_reset();
    end_reset();
    for (int i = 0; i < 10; i++) load(2, 8'h30 + 8'(i), 1'b0);
    tick();
    load(1, 8'h40, 1'b1);
    wait_strobes(11, 300);
    wait_idle(30);
    for (int i = 0; i < 4; i++) exp_q.push_back({4'b0100, 8'h30 + 8'(i)});
    exp_q.push_back({4'b0010, 8'h40});
    for (int i = 4; i < 10; i++) exp_q.push_back({4'b0100, 8'h30 + 8'(i)});
    compare_log("burst");

    // Withdrawal: requester 1 has only two bytes and no last.
    start_reset();
    end_reset();
    load(1, 8'h50, 1'b0);
    load(1, 8'h51, 1'b0);
    wait_strobes(2, 60);
    k = 0;
    while (state_dbg != 2'd1 && k < 20) begin
      tick();
      k++;
    end
    check("wd_send_state", state_dbg, 2'd1);
    check("wd_send_ack", req_ack, 4'b0000);
    check("wd_send_grant", grant, 4'b0010);
    tick();
    check("wd_idle_state", state_dbg, 2'd0);
    check("wd_idle_grant", grant, 4'b0000);
    repeat (10) tick();
    exp_q.push_back({4'b0010, 8'h50});
    exp_q.push_back({4'b0010, 8'h51});
    compare_log("wd");

    // ready drop during WAIT of byte 2 of 5.
    start_reset();
    end_reset();
    for (int i = 0; i < 5; i++) load(1, 8'h60 + 8'(i), (i == 4));
    wait_strobes(2, 60);
    tick();
    check("rdy_in_wait", state_dbg, 2'd3);
    ready = 1'b0;
    tick();
    check("rdy_state", state_dbg, 2'd0);
    check("rdy_grant", grant, 4'b0000);
    check("rdy_new_tx", new_tx_data, 1'b0);
    load(2, 8'h70, 1'b1);
    repeat (6) begin
      tick();
      check("rdy_low_ack", req_ack, 4'b0000);
    end
    check("rdy_low_strobes", n_log, 2);
    ready = 1'b1;
    wait_strobes(6, 200);
    wait_idle(30);
    exp_q.push_back({4'b0010, 8'h60});
    exp_q.push_back({4'b0010, 8'h61});
    exp_q.push_back({4'b0010, 8'h62});
    exp_q.push_back({4'b0010, 8'h63});
    exp_q.push_back({4'b0010, 8'h64});
    exp_q.push_back({4'b0100, 8'h70});
    compare_log("rdy");

    // Asynchronous reset in HOLD, then priority restarts at requester 0.
    start_reset();
    end_reset();
    load(1, 8'h81, 1'b1);
    wait_strobes(1, 40);
    wait_idle(30);
    load(2, 8'h82, 1'b1);
    k = 0;
    while (state_dbg != 2'd2 && k < 20) begin
      tick();
      k++;
    end
    check("ar_hold_strobe", new_tx_data, 1'b1);
    check("ar_hold_grant", grant, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_new_tx", new_tx_data, 1'b0);
    check("ar_grant", grant, 4'b0000);
    check("ar_ack", req_ack, 4'b0000);
    check("ar_state", state_dbg, 2'd0);
    check("ar_tx_data", tx_data, 8'h00);
    clear_sources();
    load(2, 8'h92, 1'b1);
    load(0, 8'h90, 1'b1);
    tick();
    n_log = 0;
    end_reset();
    wait_strobes(2, 60);
    wait_idle(30);
    exp_q.push_back({4'b0001, 8'h90});
    exp_q.push_back({4'b0100, 8'h92});
    compare_log("ar");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares the single AVR serial transmitter between NUM_REQ independent message sources. Sits between the requesting blocks and the serial TX user interface (tx_data / new_tx_data / tx_busy), gated by the AVR-ready indication. Arbitration is round-robin at message granularity, with a burst cap so that no source can hold the link indefinitely.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 16: maximum bytes sent per grant, ≥1; counter width is $clog2(MAX_BURST+1).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ready  in  1  AVR ready (cclk detected); low = link unusable.
- req  in  NUM_REQ  per-requester "byte available".
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i].
- req_last  in  NUM_REQ  current byte is the last byte of its message.
- req_ack  out  NUM_REQ  byte of granted requester consumed this cycle.
- grant  out  NUM_REQ  one-hot owner of the link; all zero when idle.
- tx_data  out  8  byte to the serial transmitter.
- new_tx_data  out  1  single-cycle strobe qualifying tx_data.
- tx_busy  in  1  transmitter busy.

## Operation
- States: IDLE, SEND, HOLD, WAIT.
- IDLE: if ready and any req bit is set, select the winner by round-robin, searching from index (ptr+1) mod NUM_REQ upward with wrap-around. Register grant = onehot(winner), clear byte count, go to SEND.
- SEND: if req[g] is high, assert req_ack[g] combinationally this cycle. Register tx_data <= req_data[g], new_tx_data <= 1, last_flag <= req_last[g], and count <= count+1, then go to HOLD. If req[g] is low, the message is withdrawn: clear grant, set ptr <= g, go to IDLE, and emit no strobe.
- HOLD: new_tx_data <= 0. Ignore tx_busy this cycle, covering the transmitter's one-cycle busy latency. Go to WAIT.
- WAIT: when tx_busy is low:
  - if last_flag is set or count == MAX_BURST, clear grant, set ptr <= g, go to IDLE;
  - otherwise go to SEND.
- A requester must present the next byte, or drop req, by the cycle after req_ack.
- A message cut off by MAX_BURST resumes on a later grant; the arbiter does not re-frame it.
- ready low in any state: next state is IDLE, grant cleared, new_tx_data 0, count cleared, ptr unchanged, req_ack all zero. A byte already strobed is not retried.
- req_ack is zero in every state except SEND. At most one bit is ever set, and it equals the grant bit.
- tx_data holds its last value outside the strobe cycle.

## Timing
- Reset values: state IDLE, grant 0, req_ack 0, tx_data 8'h00, new_tx_data 0, count 0, last_flag 0, ptr NUM_REQ-1 (so requester 0 wins first).
- Latency, with req rising during IDLE at cycle 0:
  - cycle 1: SEND; grant and req_ack are visible.
  - cycle 2: HOLD; new_tx_data = 1 and tx_data is valid.
  - cycle 3: WAIT begins.
- Back-to-back bytes within a grant: the next SEND follows the first WAIT cycle with tx_busy low. Minimum spacing between strobes is 3 cycles plus the busy time.
- Release to next grant: IDLE lasts at least 1 cycle. With continuous contention, the next strobe occurs 3 cycles after the releasing WAIT cycle.
- Simultaneous requests in IDLE: only the round-robin winner is granted. Losers see no req_ack and must hold req.
- A req_last of a non-granted requester is ignored.
- Reset asserted mid-byte: all outputs take their reset values immediately, because the reset is asynchronous.

## Test plan
- Single source: requester 0 sends 3 bytes 8'hA1, 8'hA2, 8'hA3 (last on 8'hA3), and the transmitter model holds busy for 10 cycles per byte.
  - Required: exactly 3 new_tx_data pulses with those bytes in order.
  - Required: strobes at cycles 2, 15, 28; grant 4'b0001 throughout, then 0.
- Round-robin: requesters 0, 1 and 3 each hold one-byte messages from reset.
  - Required: grant order 0, 1, 3, then 0 again on re-request.
  - Required: requester 2 is never granted while idle.
- Burst cap with MAX_BURST=4: requester 2 streams 10 bytes with no last, while requester 1 also requests.
  - Required: after 4 bytes, grant moves to requester 1.
  - Required: requester 2 resumes with its 5th byte on its next grant.
- Withdrawal: requester 1 drops req in SEND after 2 bytes.
  - Required: no third strobe; grant clears; IDLE the next cycle.
- ready drop: deassert ready during WAIT of byte 2 of 5.
  - Required: next cycle IDLE, grant 0, no further strobes until ready returns.
  - Required: once ready returns, arbitration restarts from ptr+1.
- Async reset: assert rst_n=0 mid-HOLD.
  - Required: new_tx_data, grant and req_ack go to 0 without waiting for a clock edge.
  - Required: after release, requester 0 has first priority.
